// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_stage
// Purpose  : Two-stage execute pipeline. E1 holds the operands of an accepted
//            operation, a combinational 2-bit-function ALU (ADD/SUB/MUL/SLT)
//            evaluates them, and E2 holds the result presented to writeback.
//            Valid/ready flow control on both sides supports full throughput
//            with back-pressure, and operands are forwarded from E1 (live ALU
//            output) and E2 so dependent back-to-back operations never stall.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            in_valid / in_ready   - upstream handshake (decode/register-read)
//            in_func               - 00 ADD, 01 SUB, 10 MUL, 11 SLT
//            in_rd, in_rs1, in_rs2 - destination and source register indices
//            in_data1, in_data2    - register-file read data for rs1/rs2
//            out_valid / out_ready - downstream handshake (writeback)
//            out_rd, out_result    - destination and result being presented
//            op_count              - completed output transfers, mod 2^16
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_func,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_result,
    output logic [15:0]       op_count
);

    localparam logic [1:0] c_FUNC_ADD = 2'b00;
    localparam logic [1:0] c_FUNC_SUB = 2'b01;
    localparam logic [1:0] c_FUNC_MUL = 2'b10;
    localparam logic [1:0] c_FUNC_SLT = 2'b11;

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    logic              r_e1_valid;
    logic [1:0]        r_e1_func;
    logic [REG_AW-1:0] r_e1_rd;
    logic [DATA_W-1:0] r_e1_op_a;
    logic [DATA_W-1:0] r_e1_op_b;

    logic              r_e2_valid;
    logic [REG_AW-1:0] r_e2_rd;
    logic [DATA_W-1:0] r_e2_result;

    logic [15:0]       r_op_count;

    // ------------------------------------------------------------------------
    // Combinational control and datapath
    // ------------------------------------------------------------------------
    logic              w_e2_take;
    logic              w_e1_take;
    logic              w_accept;
    logic              w_out_fire;
    logic [DATA_W-1:0] w_alu_result;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;

    // E2 can load whenever it is empty or its content leaves this cycle; E1
    // can load whenever it is empty or it moves into E2. This chains ready
    // straight through from out_ready so a released stall costs no bubble.
    assign w_e2_take  = !r_e2_valid || out_ready;
    assign w_e1_take  = !r_e1_valid || w_e2_take;
    assign w_accept   = in_valid && w_e1_take;
    assign w_out_fire = r_e2_valid && out_ready;

    assign in_ready   = w_e1_take;
    assign out_valid  = r_e2_valid;
    assign out_rd     = r_e2_rd;
    assign out_result = r_e2_result;
    assign op_count   = r_op_count;

    // ALU: all arithmetic wraps to DATA_W bits; SLT is an unsigned compare.
    always_comb begin
        w_alu_result = '0;
        case (r_e1_func)
            c_FUNC_ADD: w_alu_result = r_e1_op_a + r_e1_op_b;
            c_FUNC_SUB: w_alu_result = r_e1_op_a - r_e1_op_b;
            c_FUNC_MUL: w_alu_result = r_e1_op_a * r_e1_op_b;
            c_FUNC_SLT: w_alu_result = {{(DATA_W-1){1'b0}}, (r_e1_op_a < r_e1_op_b)};
            default:    w_alu_result = '0;
        endcase
    end

    // Operand selection for one source. E1 is checked before E2 because it
    // holds the younger producer of any register both stages target. An E2
    // entry still forwards on the edge it retires, since its contents are
    // valid until that edge. Register 0 short-circuits first, so an entry
    // whose rd is 0 can never be matched.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] rf_data
    );
        logic [DATA_W-1:0] v_op;
        if (rs == '0) begin
            v_op = '0;
        end else if (r_e1_valid && (r_e1_rd == rs)) begin
            v_op = w_alu_result;
        end else if (r_e2_valid && (r_e2_rd == rs)) begin
            v_op = r_e2_result;
        end else begin
            v_op = rf_data;
        end
        return v_op;
    endfunction

    always_comb begin
        w_fwd_a = select_operand(in_rs1, in_data1);
        w_fwd_b = select_operand(in_rs2, in_data2);
    end

    // ------------------------------------------------------------------------
    // E1 stage register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e1_valid <= 1'b0;
            r_e1_func  <= 2'b00;
            r_e1_rd    <= '0;
            r_e1_op_a  <= '0;
            r_e1_op_b  <= '0;
        end else if (w_accept) begin
            r_e1_valid <= 1'b1;
            r_e1_func  <= in_func;
            r_e1_rd    <= in_rd;
            r_e1_op_a  <= w_fwd_a;
            r_e1_op_b  <= w_fwd_b;
        end else if (w_e2_take) begin
            // Content moved to E2 and nothing replaced it.
            r_e1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // E2 stage register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e2_valid  <= 1'b0;
            r_e2_rd     <= '0;
            r_e2_result <= '0;
        end else if (w_e2_take) begin
            r_e2_valid  <= r_e1_valid;
            r_e2_rd     <= r_e1_rd;
            r_e2_result <= w_alu_result;
        end
    end

    // ------------------------------------------------------------------------
    // Completed-transfer counter (wraps naturally at 16 bits)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= 16'd0;
        end else if (w_out_fire) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_stage
// Purpose  : Self-checking bench for alu_exec_stage. A reference model keeps
//            the list of accepted-but-not-retired operations in program order
//            and resolves each new operand from the youngest in-flight writer
//            of that register, falling back to the register-file data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_func;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic [15:0] in_data1, in_data2;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_rd;
    logic [15:0] out_result;
    logic [15:0] op_count;

    alu_exec_stage #(.DATA_W(16), .REG_AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func    (in_func),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_result (out_result),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [2:0]  rd;
        logic [15:0] res;
        int          acc;
    } ent_t;

    ent_t        q[$];
    int          cyc = 0;
    logic [15:0] exp_cnt = 16'd0;
    int          acc_n = 0;
    int          last_acc = 0;
    logic [15:0] log_res [0:1023];
    logic [2:0]  log_rd  [0:1023];
    int          log_cyc [0:1023];
    int          log_n = 0;
    logic        rnd_bp = 1'b0;

    function automatic logic [15:0] alu_m(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        case (f)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return p[15:0];
            default: return (a < b) ? 16'd1 : 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] operand_m(input logic [2:0] rs, input logic [15:0] d);
        if (rs == 3'd0) return 16'd0;
        for (int j = q.size() - 1; j >= 0; j--)
            if (q[j].rd == rs) return q[j].res;
        return d;
    endfunction

    // Compare process: evaluated on the falling edge, after all inputs and
    // DUT outputs for the coming rising edge have settled.
    always @(negedge clk) begin
        logic ev, eir;
        ent_t e;
        cyc++;
        if (rst) begin
            q.delete();
            exp_cnt = 16'd0;
        end else begin
            // The oldest op is presented once an edge has carried it into E2.
            ev  = (q.size() > 0) && (q[0].acc <= cyc - 2);
            eir = (q.size() < 2) || out_ready;
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, eir);
            chk("op_count", op_count, exp_cnt);
            if (ev) begin
                chk("out_rd", out_rd, q[0].rd);
                chk("out_result", out_result, q[0].res);
            end
            // Accept is resolved against the pre-edge in-flight list.
            if (in_valid && eir) begin
                e.rd  = in_rd;
                e.res = alu_m(in_func, operand_m(in_rs1, in_data1), operand_m(in_rs2, in_data2));
                e.acc = cyc;
                q.push_back(e);
                acc_n++;
                last_acc = cyc;
            end
            if (ev && out_ready) begin
                log_res[log_n] = out_result;
                log_rd[log_n]  = out_rd;
                log_cyc[log_n] = cyc;
                log_n++;
                void'(q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic send(input logic [1:0] f, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [15:0] d1, input logic [15:0] d2,
                        output int stalls);
        bit done = 0;
        in_valid = 1'b1;
        in_func  = f;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_data1 = d1;
        in_data2 = d2;
        stalls   = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, base, a0;
        rst = 1'b1; in_valid = 1'b0; in_func = 2'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_data1 = '0; in_data2 = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_op_count", op_count, 0);
        chk("rst_out_result", out_result, 0);
        @(posedge clk); #1;

        // Basic ADD with latency check
        base = log_n;
        send(2'd0, 3'd1, 3'd2, 3'd3, 16'h0003, 16'h0004, st);
        a0 = last_acc;
        drain();
        chk("add_result", log_res[base], 16'h0007);
        chk("add_rd", log_rd[base], 3'd1);
        chk("add_latency", log_cyc[base] - a0, 2);
        @(negedge clk);
        chk("add_op_count", op_count, 16'd1);
        @(posedge clk); #1;

        // Arithmetic edges
        base = log_n;
        send(2'd1, 3'd1, 3'd5, 3'd6, 16'h0000, 16'h0001, st);
        send(2'd2, 3'd2, 3'd5, 3'd6, 16'h0100, 16'h0100, st);
        send(2'd3, 3'd3, 3'd5, 3'd6, 16'hFFFF, 16'h0001, st);
        send(2'd3, 3'd4, 3'd5, 3'd6, 16'h0001, 16'hFFFF, st);
        drain();
        chk("sub_wrap", log_res[base], 16'hFFFF);
        chk("mul_low", log_res[base+1], 16'h0000);
        chk("slt_false", log_res[base+2], 16'h0000);
        chk("slt_true", log_res[base+3], 16'h0001);

        // Dependent chain, no stalls expected
        base = log_n;
        send(2'd0, 3'd1, 3'd5, 3'd6, 16'h0002, 16'h0003, st);
        chk("chain_stall0", st, 0);
        send(2'd2, 3'd2, 3'd1, 3'd1, 16'hDEAD, 16'hDEAD, st);
        chk("chain_stall1", st, 0);
        send(2'd1, 3'd3, 3'd2, 3'd1, 16'hDEAD, 16'hDEAD, st);
        chk("chain_stall2", st, 0);
        drain();
        chk("chain_r1", log_res[base], 16'h0005);
        chk("chain_r2", log_res[base+1], 16'h0019);
        chk("chain_r3", log_res[base+2], 16'h0014);

        // Back-pressure: 4 ops while writeback refuses
        base = log_n;
        a0 = acc_n;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(2'd0, 3'(i + 1), 3'd6, 3'd7, 16'(16'h0010 * (i + 1)), 16'(i + 1), st);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepts", acc_n - a0, 2);
                chk("bp_in_ready", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", log_n - base, 4);
        for (int i = 0; i < 4; i++)
            chk("bp_order", log_res[base+i], 16'(17 * (i + 1)));

        // Register 0 is never written and reads as zero
        base = log_n;
        send(2'd0, 3'd0, 3'd5, 3'd6, 16'h1234, 16'h0000, st);
        send(2'd0, 3'd4, 3'd0, 3'd7, 16'h5555, 16'h0042, st);
        drain();
        chk("rs0_result", log_res[base+1], 16'h0042);

        // Randomized traffic with random back-pressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            send(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 16'($urandom), 16'($urandom), st);
        end
        rnd_bp = 1'b0;
        drain();

        // Reset with both stages full and writeback stalled
        out_ready = 1'b0;
        send(2'd0, 3'd1, 3'd5, 3'd6, 16'h0001, 16'h0001, st);
        send(2'd0, 3'd2, 3'd5, 3'd6, 16'h0002, 16'h0002, st);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = log_n;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_rd", out_rd, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_no_stale", log_n - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
# alu_exec_stage

Two-stage execute pipeline that accepts decoded ALU operations from the decode/register-read stage and returns registered results to writeback. It holds operands in an E1 register, evaluates them in the team's 2-bit-function ALU (ADD/SUB/MUL/SLT), and captures the result in an E2 register. It provides valid/ready flow control on both sides, full-throughput back-pressure, and operand forwarding from E1 and E2 so that back-to-back dependent operations need no stalls.

## Interface
- DATA_W, 16, operand/result width; must match the ALU.
- REG_AW, 3, register-index width (8 architectural registers; index 0 reads as zero).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- in_valid  input  1  decode presents an operation.
- in_ready  output  1  stage accepts; transfer when in_valid && in_ready.
- in_func  input  2  00 ADD, 01 SUB, 10 MUL, 11 SLT.
- in_rd  input  REG_AW  destination register index.
- in_rs1, in_rs2  input  REG_AW  source register indices.
- in_data1, in_data2  input  DATA_W  register-file read data for rs1/rs2.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts; transfer when out_valid && out_ready.
- out_rd  output  REG_AW  destination of the presented result.
- out_result  output  DATA_W  result.
- op_count  output  16  number of completed output transfers; wraps modulo 2^16.

## Operation
- E1 register: e1_valid, func, rd, op_a, op_b. E2 register: e2_valid, rd, result.
- ALU is purely combinational between E1 and E2: ALU_func=e1.func, srcdata_1=e1.op_a, srcdata_2=e1.op_b.
- Arithmetic follows the ALU: ADD/SUB wrap modulo 2^16; MUL keeps the low 16 bits; SLT is an unsigned compare returning 0x0001 or 0x0000.
- e2_take = !e2_valid || out_ready; e1_take = !e1_valid || (e2_take).
- in_ready = e1_take; it is combinational from out_ready with no registered bubble.
- On accept, E1 loads in_func and in_rd, plus operands after forwarding. If E1 is not loaded and e2_take is true, e1_valid clears.
- On e2_take, E2 loads e1_valid, e1.rd, and the ALU result. Data fields are only meaningful while the matching valid is set.
- Forwarding is evaluated per source at accept time, with priority in this order:
  - If rsN == 0: operand is 0, ignoring in_dataN.
  - Else if e1_valid and e1.rd == rsN: operand is the live ALU output, because E1 is the younger producer.
  - Else if e2_valid and e2.rd == rsN: operand is e2.result.
  - Else: operand is in_dataN.
- An E1/E2 entry with rd == 0 never forwards.
- Forwarding from E2 is valid even when E2 retires in the same cycle.
- op_count increments by 1 on every out transfer.

## Timing
- Reset values: e1_valid=0, e2_valid=0, out_valid=0, op_count=0, out_rd=0, out_result=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards both stages. No output transfer is reported for in-flight operations.
- Latency: an operation accepted at edge N has out_valid=1 after edge N+1, presenting its result.
- Throughput: one op per cycle while out_ready=1.
- Stall: with out_ready=0 and both stages full, in_ready=0. out_valid, out_rd and out_result hold stable until the transfer.
- Stall release: when out_ready returns to 1, the same-cycle transfer, E1→E2 advance and a new accept all occur on one edge.
- Simultaneous accept and retire on the same edge are legal. Forwarding uses the pre-edge E1/E2 contents.
- No combinational path from in_valid to out_valid.

## Test plan
- Reset, then ADD 0x0003+0x0004 → rd=1. Required: out_valid two edges after accept, out_result=0x0007, out_rd=1, op_count=1.
- Arithmetic edges:
  - SUB 0x0000-0x0001 → 0xFFFF.
  - MUL 0x0100*0x0100 → 0x0000.
  - SLT 0xFFFF,0x0001 → 0x0000.
  - SLT 0x0001,0xFFFF → 0x0001.
- Dependent chain, out_ready=1, one op per cycle:
  - r1=2+3.
  - r2=r1*r1 with stale in_data1/in_data2=0xDEAD.
  - r3=r2-r1.
  - Required: results 0x0005, 0x0019, 0x0014, and in_ready held at 1 throughout.
- Back-pressure: issue 4 ops with out_ready=0. Required: in_ready drops after 2 accepts, out_result is stable. Releasing out_ready yields all 4 results in order, with no loss or duplication.
- rs=0 handling: an op writing rd=0 (value 0x1234), followed by an op reading rs1=0 with in_data1=0x5555, yields operand 0. The ADD result equals op_b.
- Assert rst while both stages are full and out_ready=0. Required: next cycle out_valid=0, op_count=0, in_ready=1, and no stale result appears afterwards.
